rr_arbiter_param: RTL and testbench
===================================

Name: rr_arbiter_param

Overview:
Parametrised round-robin arbiter for N requesters. It is the successor to the fixed 4-input, counter-sliced arbiter. It adds:
- a generic requester count;
- a selectable mode: fixed time-slot (TDM) or work-conserving (skips idle requesters);
- an enable input;
- a grant-lock feature for multi-cycle transactions;
- registered one-hot and encoded grant outputs.

It sits between the N request sources and the shared downstream resource in the pipeline.

Parameters:
N, 4, number of requesters (1..32)
IDX_W, 2, index width; must satisfy 2**IDX_W >= N (IDX_W=1 when N=1)
MODE, 1, 0 = fixed TDM slot rotation; 1 = work-conserving round robin

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
en  input  1  advance enable; 0 freezes all state and outputs
req  input  N  request vector, bit i = requester i
lock  input  1  hold current grant (MODE 1 only; ignored in MODE 0)
gnt  output  N  registered one-hot grant
gnt_idx  output  IDX_W  registered index of last granted or slotted requester
gnt_valid  output  1  registered; 1 when gnt is non-zero
ptr_dbg  output  IDX_W  current priority pointer (debug/verification)

Behaviour:
- Reset (rst=0, asynchronous): ptr=0, gnt=0, gnt_idx=0, gnt_valid=0, ptr_dbg=0. Reset release takes effect at the first rising edge with rst=1.
- All outputs are registered. Latency is 1 cycle: req and lock are sampled at edge k, and the result is visible after edge k.
- en=0: all registers hold their values, including ptr. req is ignored.
- Pointer arithmetic is modulo N, not 2**IDX_W:
  - ptr == N-1 wraps to 0.
  - ptr never takes a value >= N.
  - N=1: ptr stays 0.
- MODE 0 (TDM), per enabled cycle:
  - gnt_idx <= ptr
  - gnt_valid <= req[ptr]
  - gnt <= req[ptr] ? onehot(ptr) : 0
  - ptr <= ptr+1 mod N, unconditionally, whether or not req[ptr] is set
  - With N=4 this reproduces the legacy arbiter slot sequence.
- MODE 1 (work-conserving), per enabled cycle, evaluated in priority order:
  1. Lock hold: gnt_valid=1 and lock=1 and req[gnt_idx]=1 -> gnt, gnt_idx, gnt_valid and ptr all unchanged.
  2. Search: scan indices ptr, ptr+1, ..., ptr+N-1 (mod N) for the first i with req[i]=1. If found: gnt <= onehot(i), gnt_idx <= i, gnt_valid <= 1, ptr <= i+1 mod N.
  3. No request: gnt <= 0, gnt_valid <= 0; gnt_idx and ptr hold.
- Lock release:
  - If lock=1 but the held requester has dropped req, the lock is ignored and a normal search runs that cycle.
  - Lock with gnt_valid=0 has no effect.
- Fairness (MODE 1, lock never asserted): with all N requesters continuously asserted, each is granted exactly once every N cycles. No requester waits more than N-1 grants of others.
- Invariants:
  - gnt is zero or one-hot.
  - gnt_valid == |gnt.
  - When gnt_valid=1, gnt[gnt_idx]=1.
- Reset mid-operation: outputs clear immediately. Any active lock is abandoned, and search restarts from index 0 after release.
- req bits may change every cycle; the arbiter uses no request history beyond ptr and the current grant.

Test Plan:
1. Reset/idle: N=4, MODE=1. Assert rst=0 mid-grant -> gnt=0000, gnt_valid=0, ptr_dbg=0 with no clock edge. Release with req=0 -> outputs stay 0.
2. Full-load rotation: MODE=1, req=1111 for 8 cycles -> gnt sequence 0001, 0010, 0100, 1000, 0001, ... and gnt_idx sequence 0, 1, 2, 3, 0, ...
3. Skip idle: MODE=1, ptr=0, req=1010 held -> gnt 0010, 1000, 0010, 1000. Then req=0000 -> gnt_valid=0 and gnt_idx holds at 3.
4. Lock: MODE=1, req=1111, lock=1 from the first grant (idx 0) for 3 cycles -> gnt=0001 held 4 cycles in total. Drop lock -> next gnt=0010. Repeat with lock=1 but req[0] dropped -> grant moves on immediately.
5. TDM legacy equivalence: MODE=0, N=4, req=0100 -> gnt_valid pattern 0, 0, 1, 0, 0, 0, 1, 0 with gnt_idx 0, 1, 2, 3, ... regardless of req.
6. Non-power-of-2 and enable: N=3, IDX_W=2, MODE=1, req=111 -> gnt_idx 0, 1, 2, 0 and ptr_dbg never equals 3. Deassert en for 2 cycles mid-sequence -> all outputs and ptr_dbg frozen, sequence resumes unchanged afterwards.

Source files
------------

// File: rtl/rr_arbiter_param.sv
`default_nettype none
// ==========================================================================
// rr_arbiter_param : N-way round-robin arbiter, TDM or work-conserving, lock
// Revision: 1.0
// ==========================================================================
module rr_arbiter_param #(
   parameter int N     = 4,
   parameter int IDX_W = 2,
   parameter int MODE  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N-1:0]     req,
   input  logic             lock,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] ptr_dbg
);

   localparam logic [IDX_W:0]   N_EXT  = (IDX_W+1)'(N);
   localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N - 1);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] nxt_ptr;
   logic [IDX_W-1:0] nxt_idx;
   logic [N-1:0]     nxt_gnt;
   logic             nxt_valid;

   function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) begin
         if (idx == IDX_W'(i)) v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic req_at(input logic [N-1:0] vec, input logic [IDX_W-1:0] idx);
      return |(vec & onehot(idx));
   endfunction

   // Wrap at N rather than 2**IDX_W so ptr never reaches an unused index.
   function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] idx);
      return (idx == LAST_I) ? '0 : idx + IDX_W'(1);
   endfunction

   generate
      if (MODE == 0) begin : g_tdm
         always_comb begin
            nxt_ptr   = inc_mod(ptr);
            nxt_idx   = ptr;
            nxt_gnt   = req & onehot(ptr);
            nxt_valid = req_at(req, ptr);
         end
      end else begin : g_wc
         logic [IDX_W:0]   cand_sum;
         logic [IDX_W-1:0] cand;
         logic [IDX_W-1:0] found_idx;
         logic             found;
         logic             hold;

         // Rotating scan starting at ptr; first requester found wins.
         always_comb begin
            found     = 1'b0;
            found_idx = ptr;
            cand_sum  = '0;
            cand      = '0;
            for (int off = 0; off < N; off++) begin
               cand_sum = {1'b0, ptr} + (IDX_W+1)'(off);
               if (cand_sum >= N_EXT) cand_sum = cand_sum - N_EXT;
               cand = cand_sum[IDX_W-1:0];
               if (!found && req_at(req, cand)) begin
                  found     = 1'b1;
                  found_idx = cand;
               end
            end
         end

         assign hold = gnt_valid && lock && req_at(req, gnt_idx);

         always_comb begin
            nxt_ptr   = ptr;
            nxt_idx   = gnt_idx;
            nxt_gnt   = gnt;
            nxt_valid = gnt_valid;
            if (!hold) begin
               if (found) begin
                  nxt_ptr   = inc_mod(found_idx);
                  nxt_idx   = found_idx;
                  nxt_gnt   = onehot(found_idx);
                  nxt_valid = 1'b1;
               end else begin
                  nxt_gnt   = '0;
                  nxt_valid = 1'b0;
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr       <= '0;
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
      end else if (en) begin
         ptr       <= nxt_ptr;
         gnt       <= nxt_gnt;
         gnt_idx   <= nxt_idx;
         gnt_valid <= nxt_valid;
      end
   end

   assign ptr_dbg = ptr;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_param.sv
`default_nettype none
// Bench for rr_arbiter_param: N=4 work-conserving, N=4 TDM and N=3 work-conserving
// instances against a behavioural model, plus literal checks of the directed plan.
module tb_rr_arbiter_param;

   typedef struct {
      int ptr;
      int idx;
      bit v;
   } mstate_t;

   logic       clk;
   logic       rst;
   logic       en;
   logic       lock;
   logic [3:0] req4;
   logic [2:0] req3;

   logic [3:0] g4w, g4t;
   logic [1:0] i4w, i4t, p4w, p4t;
   logic       v4w, v4t;
   logic [2:0] g3w;
   logic [1:0] i3w, p3w;
   logic       v3w;

   int  n_vec = 0;
   int  n_err = 0;
   bit  chk_on = 0;

   mstate_t m4w, m4t, m3w;

   assign req3 = req4[2:0];

   rr_arbiter_param #(.N(4), .IDX_W(2), .MODE(1)) u_d4w (
      .clk(clk), .rst(rst), .en(en), .req(req4), .lock(lock),
      .gnt(g4w), .gnt_idx(i4w), .gnt_valid(v4w), .ptr_dbg(p4w));

   rr_arbiter_param #(.N(4), .IDX_W(2), .MODE(0)) u_d4t (
      .clk(clk), .rst(rst), .en(en), .req(req4), .lock(lock),
      .gnt(g4t), .gnt_idx(i4t), .gnt_valid(v4t), .ptr_dbg(p4t));

   rr_arbiter_param #(.N(3), .IDX_W(2), .MODE(1)) u_d3w (
      .clk(clk), .rst(rst), .en(en), .req(req3), .lock(lock),
      .gnt(g3w), .gnt_idx(i3w), .gnt_valid(v3w), .ptr_dbg(p3w));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic mstate_t model_step(mstate_t s, int n, int mode, bit [31:0] r, bit lk);
      mstate_t t;
      t = s;
      if (mode == 0) begin
         t.idx = s.ptr;
         t.v   = r[s.ptr];
         t.ptr = (s.ptr + 1) % n;
         return t;
      end
      if (s.v && lk && r[s.idx]) return t;
      for (int k = 0; k < n; k++) begin
         int c;
         c = (s.ptr + k) % n;
         if (r[c]) begin
            t.idx = c;
            t.v   = 1'b1;
            t.ptr = (c + 1) % n;
            return t;
         end
      end
      t.v = 1'b0;
      return t;
   endfunction

   function automatic logic [31:0] exp_gnt(mstate_t s);
      return s.v ? (32'd1 << s.idx) : 32'd0;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m4w <= '{0, 0, 1'b0};
         m4t <= '{0, 0, 1'b0};
         m3w <= '{0, 0, 1'b0};
      end else if (en) begin
         m4w <= model_step(m4w, 4, 1, {28'd0, req4}, lock);
         m4t <= model_step(m4t, 4, 0, {28'd0, req4}, lock);
         m3w <= model_step(m3w, 3, 1, {29'd0, req3}, lock);
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("m4w_gnt", {28'd0, g4w}, exp_gnt(m4w));
         chk("m4w_idx", {30'd0, i4w}, m4w.idx);
         chk("m4w_vld", {31'd0, v4w}, {31'd0, m4w.v});
         chk("m4w_ptr", {30'd0, p4w}, m4w.ptr);
         chk("m4t_gnt", {28'd0, g4t}, exp_gnt(m4t));
         chk("m4t_idx", {30'd0, i4t}, m4t.idx);
         chk("m4t_vld", {31'd0, v4t}, {31'd0, m4t.v});
         chk("m4t_ptr", {30'd0, p4t}, m4t.ptr);
         chk("m3w_gnt", {29'd0, g3w}, exp_gnt(m3w));
         chk("m3w_idx", {30'd0, i3w}, m3w.idx);
         chk("m3w_vld", {31'd0, v3w}, {31'd0, m3w.v});
         chk("m3w_ptr", {30'd0, p3w}, m3w.ptr);
         chk("m3w_ptr_lt3", {31'd0, (p3w < 2'd3)}, 32'd1);
      end
   end

   // Inputs change 2 time units after a rising edge; the result of the
   // previous inputs is then already visible on the registered outputs.
   task automatic cyc(input logic [3:0] r, input logic l, input logic e);
      req4 = r;
      lock = l;
      en   = e;
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      #1;
      rst = 1'b1;
      req4 = 4'b0000;
      lock = 1'b0;
   endtask

   logic [5:0] tbl [0:11];

   initial begin
      tbl = '{6'b10_1011, 6'b11_1011, 6'b11_0011, 6'b11_0000, 6'b10_1000, 6'b11_0110,
              6'b01_0110, 6'b11_0110, 6'b11_0100, 6'b10_1111, 6'b00_1111, 6'b10_0001};
      rst  = 1'b0;
      en   = 1'b1;
      lock = 1'b0;
      req4 = 4'b0000;
      @(posedge clk);
      #2;
      chk("rst_gnt", {28'd0, g4w}, 32'd0);
      chk("rst_vld", {31'd0, v4w}, 32'd0);
      chk("rst_idx", {30'd0, i4w}, 32'd0);
      chk("rst_ptr", {30'd0, p4w}, 32'd0);
      rst    = 1'b1;
      chk_on = 1'b1;

      // Idle after reset
      for (int k = 0; k < 2; k++) begin
         cyc(4'b0000, 1'b0, 1'b1);
         chk("idle_gnt", {28'd0, g4w}, 32'd0);
         chk("idle_vld", {31'd0, v4w}, 32'd0);
      end

      // Full-load rotation
      for (int k = 0; k < 8; k++) begin
         cyc(4'b1111, 1'b0, 1'b1);
         chk("rot_gnt", {28'd0, g4w}, 32'd1 << (k % 4));
         chk("rot_idx", {30'd0, i4w}, k % 4);
      end

      // Asynchronous reset while a grant is active
      chk("pre_rst_vld", {31'd0, v4w}, 32'd1);
      rst = 1'b0;
      #1;
      chk("async_gnt", {28'd0, g4w}, 32'd0);
      chk("async_vld", {31'd0, v4w}, 32'd0);
      chk("async_ptr", {30'd0, p4w}, 32'd0);
      chk("async_idx", {30'd0, i4w}, 32'd0);
      rst  = 1'b1;
      req4 = 4'b0000;
      cyc(4'b0000, 1'b0, 1'b1);
      chk("rel_gnt", {28'd0, g4w}, 32'd0);
      chk("rel_vld", {31'd0, v4w}, 32'd0);

      // Skip idle requesters
      for (int k = 0; k < 4; k++) begin
         cyc(4'b1010, 1'b0, 1'b1);
         chk("skip_gnt", {28'd0, g4w}, (k % 2 == 0) ? 32'h2 : 32'h8);
      end
      cyc(4'b0000, 1'b0, 1'b1);
      chk("skip_none_vld", {31'd0, v4w}, 32'd0);
      chk("skip_none_idx", {30'd0, i4w}, 32'd3);

      // Lock: asserted while gnt_valid=0 is ignored, then holds idx 0
      for (int k = 0; k < 4; k++) begin
         cyc(4'b1111, 1'b1, 1'b1);
         chk("lock_hold", {28'd0, g4w}, 32'h1);
      end
      cyc(4'b1111, 1'b0, 1'b1);
      chk("lock_drop", {28'd0, g4w}, 32'h2);
      cyc(4'b1111, 1'b1, 1'b1);
      chk("lock_hold2", {28'd0, g4w}, 32'h2);
      cyc(4'b1101, 1'b1, 1'b1);
      chk("lock_reqdrop", {28'd0, g4w}, 32'h4);
      chk("lock_reqdrop_ptr", {30'd0, p4w}, 32'd3);

      // TDM slot sequence
      pulse_reset();
      for (int k = 0; k < 8; k++) begin
         cyc(4'b0100, 1'b0, 1'b1);
         chk("tdm_vld", {31'd0, v4t}, (k % 4 == 2) ? 32'd1 : 32'd0);
         chk("tdm_idx", {30'd0, i4t}, k % 4);
         chk("tdm_gnt", {28'd0, g4t}, (k % 4 == 2) ? 32'h4 : 32'h0);
      end

      // N=3 wrap and enable freeze
      pulse_reset();
      for (int k = 0; k < 4; k++) begin
         cyc(4'b0111, 1'b0, 1'b1);
         chk("n3_idx", {30'd0, i3w}, k % 3);
      end
      chk("n3_ptr", {30'd0, p3w}, 32'd1);
      for (int k = 0; k < 2; k++) begin
         cyc(4'b0111, 1'b0, 1'b0);
         chk("frz_idx", {30'd0, i3w}, 32'd0);
         chk("frz_gnt", {29'd0, g3w}, 32'h1);
         chk("frz_ptr", {30'd0, p3w}, 32'd1);
      end
      for (int k = 0; k < 3; k++) begin
         cyc(4'b0111, 1'b0, 1'b1);
         chk("resume_idx", {30'd0, i3w}, (k + 1) % 3);
      end

      // Mixed request/lock/enable vectors, checked against the model only
      for (int k = 0; k < 12; k++) begin
         cyc(tbl[k][3:0], tbl[k][4], tbl[k][5]);
      end

      @(negedge clk);
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
